// File: rtl/lsu_mem_stage_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM states, reset value.
package lsu_mem_stage_pkg;

  localparam logic [63:0] DataZero = '0;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [2:0] F3_SD  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational access shaping: legality check, byte enables, store lane
// replication and load shift with sign/zero extension.
module lsu_align
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            fault,
  output logic [7:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_data
);

  logic [1:0]      size;
  logic            illegal;
  logic            misaligned;
  logic [XLEN-1:0] shifted;

  assign size = funct3[1:0];

  // Illegal codes and natural-alignment violations
  always_comb begin
    illegal = mem_write ? funct3[2] : (funct3 == 3'd7);
    case (size)
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      2'd3:    misaligned = |off;
      default: misaligned = 1'b0;
    endcase
    fault = illegal | misaligned;
  end

  // Byte enables and replicated store data by access size
  always_comb begin
    case (size)
      2'd0: begin
        be        = 8'h01 << off;
        wdata_rep = {8{wdata[7:0]}};
      end
      2'd1: begin
        be        = 8'h03 << off;
        wdata_rep = {4{wdata[15:0]}};
      end
      2'd2: begin
        be        = 8'h0F << off;
        wdata_rep = {2{wdata[31:0]}};
      end
      default: begin
        be        = 8'hFF;
        wdata_rep = wdata;
      end
    endcase
  end

  assign shifted = mem_rdata >> {off, 3'b000};

  // Load extension by funct3
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  load_data = {56'd0, shifted[7:0]};
      F3_LHU:  load_data = {48'd0, shifted[15:0]};
      F3_LWU:  load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Multi-cycle load/store unit: request/grant/response FSM with registered outputs.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [XLEN-1:0]   rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [7:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  lsu_state_t        state, state_n;
  logic              wr_q, wr_n;
  logic [2:0]        f3_q, f3_n;
  logic [2:0]        off_q, off_n;
  logic              req_n, we_n, done_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        be_n;
  logic [XLEN-1:0]   wd_n, rdata_n;

  logic              al_write;
  logic [2:0]        al_f3;
  logic [2:0]        al_off;
  logic              al_fault;
  logic [7:0]        al_be;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_load;

  // In IDLE the aligner sees the live request; afterwards the captured one
  assign al_write = (state == ST_IDLE) ? mem_write : wr_q;
  assign al_f3    = (state == ST_IDLE) ? funct3    : f3_q;
  assign al_off   = (state == ST_IDLE) ? addr[2:0] : off_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .mem_write (al_write),
    .funct3    (al_f3),
    .off       (al_off),
    .wdata     (wdata),
    .mem_rdata (dmem_rdata),
    .fault     (al_fault),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .load_data (al_load)
  );

  assign busy = (state != ST_IDLE);

  // Next-state and next-output decode
  always_comb begin
    state_n = state;
    wr_n    = wr_q;
    f3_n    = f3_q;
    off_n   = off_q;
    req_n   = dmem_req;
    we_n    = dmem_we;
    addr_n  = dmem_addr;
    be_n    = dmem_be;
    wd_n    = dmem_wdata;
    rdata_n = rdata;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          wr_n  = mem_write;
          f3_n  = funct3;
          off_n = addr[2:0];
          if (al_fault) begin
            state_n = ST_RESP;
            done_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = ST_REQ;
            req_n   = 1'b1;
            we_n    = mem_write;
            addr_n  = {addr[ADDR_W-1:3], 3'b000};
            be_n    = al_be;
            wd_n    = al_wdata;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          req_n = 1'b0;
          // Grant and response together complete exactly like WAIT would
          if (dmem_rvalid) begin
            state_n = ST_RESP;
            done_n  = 1'b1;
            if (!wr_q) rdata_n = al_load;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_n = ST_RESP;
          done_n  = 1'b1;
          if (!wr_q) rdata_n = al_load;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wr_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= DataZero;
      rdata      <= DataZero;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      wr_q       <= wr_n;
      f3_q       <= f3_n;
      off_q      <= off_n;
      dmem_req   <= req_n;
      dmem_we    <= we_n;
      dmem_addr  <= addr_n;
      dmem_be    <= be_n;
      dmem_wdata <= wd_n;
      rdata      <= rdata_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with hand-computed expectations.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, err;
  logic [63:0] rdata;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr;
  logic [7:0]  dmem_be;
  logic [63:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [63:0] dmem_rdata = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  lsu_mem_stage #(.XLEN(64), .ADDR_W(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then drop start
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd);
    start = 1'b1; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    tick();
    start = 1'b0;
  endtask

  // From the first REQ cycle: grant after gdly idle cycles, response rdly
  // cycles after grant (0 = same cycle). Returns just after the done edge.
  task automatic serve(input int gdly, input int rdly, input logic [63:0] rd);
    repeat (gdly) tick();
    dmem_gnt = 1'b1;
    if (rdly == 0) begin
      dmem_rvalid = 1'b1; dmem_rdata = rd;
    end
    chk("pre_done", {63'd0, done}, 64'd0);
    tick();
    dmem_gnt = 1'b0;
    if (rdly > 0) begin
      repeat (rdly - 1) tick();
      dmem_rvalid = 1'b1; dmem_rdata = rd;
      chk("pre_done_w", {63'd0, done}, 64'd0);
      tick();
    end
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_req",  {63'd0, dmem_req}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_be",   {56'd0, dmem_be}, 64'd0);
    chk("rst_wd",   dmem_wdata, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // LB at offset 5: byte 5 of 0011_2233_4455_66F8 is 0x22
    issue(1'b0, 3'd0, 64'h1005, 64'h0);
    chk("lb_req",  {63'd0, dmem_req}, 64'd1);
    chk("lb_we",   {63'd0, dmem_we}, 64'd0);
    chk("lb_addr", dmem_addr, 64'h1000);
    chk("lb_be",   {56'd0, dmem_be}, 64'h20);
    chk("lb_busy", {63'd0, busy}, 64'd1);
    serve(0, 1, 64'h0011_2233_4455_66F8);
    chk("lb_done", {63'd0, done}, 64'd1);
    chk("lb_err",  {63'd0, err}, 64'd0);
    chk("lb_rdata", rdata, 64'h22);
    tick();
    chk("lb_done_pulse", {63'd0, done}, 64'd0);
    chk("lb_idle", {63'd0, busy}, 64'd0);

    // LBU and LB of a negative byte at offset 0
    issue(1'b0, 3'd4, 64'h1000, 64'h0);
    serve(0, 1, 64'h0011_2233_4455_66F8);
    chk("lbu_rdata", rdata, 64'hF8);
    tick();
    issue(1'b0, 3'd0, 64'h1000, 64'h0);
    serve(0, 1, 64'h0011_2233_4455_66F8);
    chk("lb_neg", rdata, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();

    // LW / LWU from the upper word
    issue(1'b0, 3'd2, 64'h2004, 64'h0);
    chk("lw_be", {56'd0, dmem_be}, 64'hF0);
    serve(0, 1, 64'h8000_0001_1234_5678);
    chk("lw_rdata", rdata, 64'hFFFF_FFFF_8000_0001);
    tick();
    issue(1'b0, 3'd6, 64'h2004, 64'h0);
    serve(0, 1, 64'h8000_0001_1234_5678);
    chk("lwu_rdata", rdata, 64'h0000_0000_8000_0001);
    tick();

    // SH: replicated half, upper byte enables, rdata untouched
    issue(1'b1, 3'd1, 64'h3006, 64'h1111_2222_3333_ABCD);
    chk("sh_we",   {63'd0, dmem_we}, 64'd1);
    chk("sh_be",   {56'd0, dmem_be}, 64'hC0);
    chk("sh_wd",   dmem_wdata, 64'hABCD_ABCD_ABCD_ABCD);
    chk("sh_addr", dmem_addr, 64'h3000);
    serve(0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sh_done", {63'd0, done}, 64'd1);
    chk("sh_err",  {63'd0, err}, 64'd0);
    chk("sh_rdata", rdata, 64'h0000_0000_8000_0001);
    tick();

    // SB replication
    issue(1'b1, 3'd0, 64'h3003, 64'h0000_0000_0000_125A);
    chk("sb_be", {56'd0, dmem_be}, 64'h08);
    chk("sb_wd", dmem_wdata, 64'h5A5A_5A5A_5A5A_5A5A);
    serve(0, 1, 64'h0);
    tick();

    // Misaligned SW: done+err next cycle, no request
    issue(1'b1, 3'd2, 64'h4002, 64'h0);
    chk("sw_mis_done", {63'd0, done}, 64'd1);
    chk("sw_mis_err",  {63'd0, err}, 64'd1);
    chk("sw_mis_req",  {63'd0, dmem_req}, 64'd0);
    chk("sw_mis_rdata", rdata, 64'h0000_0000_8000_0001);
    tick();
    chk("sw_mis_err_clr", {63'd0, err}, 64'd0);
    chk("sw_mis_idle", {63'd0, busy}, 64'd0);

    // Illegal load funct3=7 and illegal store funct3=4
    issue(1'b0, 3'd7, 64'h4000, 64'h0);
    chk("ld7_done", {63'd0, done}, 64'd1);
    chk("ld7_err",  {63'd0, err}, 64'd1);
    chk("ld7_req",  {63'd0, dmem_req}, 64'd0);
    tick();
    issue(1'b1, 3'd4, 64'h4000, 64'h0);
    chk("st4_err",  {63'd0, err}, 64'd1);
    chk("st4_req",  {63'd0, dmem_req}, 64'd0);
    tick();

    // Delayed grant with start toggling while busy
    issue(1'b0, 3'd3, 64'h5000, 64'h0);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      tick();
      chk("slow_req",  {63'd0, dmem_req}, 64'd1);
      chk("slow_addr", dmem_addr, 64'h5000);
      chk("slow_be",   {56'd0, dmem_be}, 64'hFF);
    end
    dmem_gnt = 1'b1;
    start = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("slow_req_drop", {63'd0, dmem_req}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      start = ~start;
      tick();
      chk("slow_wait", {63'd0, done}, 64'd0);
    end
    start = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0123_4567;
    tick();
    dmem_rvalid = 1'b0;
    chk("slow_done", {63'd0, done}, 64'd1);
    chk("ld_rdata", rdata, 64'hDEAD_BEEF_0123_4567);
    tick();
    chk("slow_single", {63'd0, done}, 64'd0);
    chk("slow_no_req", {63'd0, dmem_req}, 64'd0);
    tick();
    chk("slow_no_req2", {63'd0, dmem_req | busy}, 64'd0);

    // Grant and response in the same cycle
    issue(1'b0, 3'd5, 64'h6002, 64'h0);
    serve(0, 0, 64'h0000_0000_F00D_0000);
    chk("fast_done", {63'd0, done}, 64'd1);
    chk("lhu_rdata", rdata, 64'h0000_0000_0000_F00D);
    tick();

    // Reset while waiting; late response afterwards is dropped
    issue(1'b0, 3'd0, 64'h7000, 64'h0);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk("w_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_rdata", rdata, 64'd0);
    chk("mid_rst_addr", dmem_addr, 64'd0);
    tick();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 64'h55;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_done", {63'd0, done}, 64'd0);
    chk("late_rdata", rdata, 64'd0);
    tick();
    chk("late_done2", {63'd0, done | busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
